// File: rtl/servo_pwm_array.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_array
// Purpose  : Multi-channel servo PWM generator with Avalon-MM register slave.
//            One shared microsecond prescaler and frame counter drive NUM_CH
//            pulse outputs. Each channel has a per-frame slew limit. A
//            "settled" interrupt fires when every channel has reached its
//            target.
// Options  : SERVO_PWM_INVERT_EN adds a per-channel output polarity register
//            at word address 2+NUM_CH.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_array #(
    parameter int NUM_CH       = 4,
    parameter int CLK_HZ       = 50000000,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_US       = 1000,
    parameter int MAX_US       = 2000,
    parameter int DEFAULT_STEP = 0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [4:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam logic [15:0] C_PRESC_LAST = 16'(CLK_HZ / 1000000 - 1);
    localparam logic [15:0] C_FRAME_LAST = 16'(PERIOD_US - 1);
    localparam logic [15:0] C_MIN        = 16'(MIN_US);
    localparam logic [15:0] C_MAX        = 16'(MAX_US);
    localparam logic [15:0] C_MID        = 16'((MIN_US + MAX_US) / 2);
    localparam logic [15:0] C_DEF_STEP   = 16'(DEFAULT_STEP);
    localparam logic [4:0]  C_POL_ADDR   = 5'(2 + NUM_CH);

    logic              en_q, en_d;
    logic              irq_en_q, irq_en_d;
    logic [15:0]       step_q, step_d;
    logic              pend_q, pend_d;
    logic [15:0]       presc_q, presc_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic [15:0]       tgt_q [NUM_CH];
    logic [15:0]       tgt_d [NUM_CH];
    logic [15:0]       cur_q [NUM_CH];
    logic [15:0]       cur_d [NUM_CH];
    logic [15:0]       diff  [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [NUM_CH-1:0] moving, moving_post;
    logic              irq_q, irq_d;
    logic [31:0]       rdata_q, rdata_d, rmux;
    logic              wr_ctrl, wr_stat, us_tick, boundary;
    logic [15:0]       wclamp;
`ifdef SERVO_PWM_INVERT_EN
    logic [NUM_CH-1:0] pol_q, pol_d;
`endif

    // Register decode, timebase, slew update, interrupt and read mux
    always_comb begin
        wr_ctrl  = avs_write && (avs_address == 5'd0);
        wr_stat  = avs_write && (avs_address == 5'd1);
        en_d     = wr_ctrl ? avs_writedata[0]     : en_q;
        irq_en_d = wr_ctrl ? avs_writedata[1]     : irq_en_q;
        step_d   = wr_ctrl ? avs_writedata[31:16] : step_q;

        // Counters run off the next EN value: the enabling write cycle is the
        // first cycle of fcnt=0, and a disable clears them on the next cycle.
        us_tick  = en_d && (presc_q == C_PRESC_LAST);
        boundary = us_tick && (fcnt_q == C_FRAME_LAST);

        if (!en_d || us_tick) presc_d = '0;
        else                  presc_d = presc_q + 16'd1;

        if (!en_d || boundary) fcnt_d = '0;
        else if (us_tick)      fcnt_d = fcnt_q + 16'd1;
        else                   fcnt_d = fcnt_q;

        if (avs_writedata[15:0] < C_MIN)      wclamp = C_MIN;
        else if (avs_writedata[15:0] > C_MAX) wclamp = C_MAX;
        else                                  wclamp = avs_writedata[15:0];

        for (int i = 0; i < NUM_CH; i++) begin
            tgt_d[i] = (avs_write && (avs_address == 5'(2 + i))) ? wclamp : tgt_q[i];
            diff[i]  = (cur_q[i] > tgt_q[i]) ? (cur_q[i] - tgt_q[i]) : (tgt_q[i] - cur_q[i]);
            cur_d[i] = cur_q[i];
            // Slew uses the pre-write target; a same-cycle write waits a frame
            if (boundary) begin
                if ((step_q == 16'd0) || (diff[i] <= step_q)) cur_d[i] = tgt_q[i];
                else if (tgt_q[i] > cur_q[i])                 cur_d[i] = cur_q[i] + step_q;
                else                                          cur_d[i] = cur_q[i] - step_q;
            end
            moving[i]      = (cur_q[i] != tgt_q[i]);
            moving_post[i] = (cur_d[i] != tgt_q[i]);
            pwm_d[i]       = en_d && (fcnt_q < cur_q[i]);
        end

        // Set has priority over write-1-clear
        pend_d = pend_q;
        if (wr_stat && avs_writedata[31])                  pend_d = 1'b0;
        if (boundary && (|moving) && !(|moving_post))      pend_d = 1'b1;
        irq_d = pend_q && irq_en_q;

        rmux = '0;
        if (avs_address == 5'd0) rmux = {step_q, 14'd0, irq_en_q, en_q};
        if (avs_address == 5'd1) begin
            rmux[NUM_CH-1:0] = moving;
            rmux[31]         = pend_q;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (avs_address == 5'(2 + i)) rmux = {cur_q[i], tgt_q[i]};
        end
`ifdef SERVO_PWM_INVERT_EN
        pol_d = (avs_write && (avs_address == C_POL_ADDR)) ? avs_writedata[NUM_CH-1:0] : pol_q;
        if (avs_address == C_POL_ADDR) rmux[NUM_CH-1:0] = pol_q;
`else
        if (avs_address == C_POL_ADDR) rmux = '0;
`endif
        rdata_d = avs_read ? rmux : rdata_q;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            step_q   <= C_DEF_STEP;
            pend_q   <= 1'b0;
            presc_q  <= '0;
            fcnt_q   <= '0;
            pwm_q    <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= C_MID;
                cur_q[i] <= C_MID;
            end
`ifdef SERVO_PWM_INVERT_EN
            pol_q    <= '0;
`endif
        end else begin
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            step_q   <= step_d;
            pend_q   <= pend_d;
            presc_q  <= presc_d;
            fcnt_q   <= fcnt_d;
            pwm_q    <= pwm_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= tgt_d[i];
                cur_q[i] <= cur_d[i];
            end
`ifdef SERVO_PWM_INVERT_EN
            pol_q    <= pol_d;
`endif
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
`ifdef SERVO_PWM_INVERT_EN
    assign pwm_out      = pwm_q ^ pol_q;
`else
    assign pwm_out      = pwm_q;
`endif

endmodule
`default_nettype wire
